// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch unit: word width, fetch FSM states
// and the {pc, instruction} pair held in the prefetch buffer.
package instr_fetch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Prefetch buffer: DEPTH entries of {pc, instruction} with push, pop and flush.
// The head reads as zero while empty so the core never sees stale words.
module instr_fifo
    import instr_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Flush has priority: a redirect discards both the stored words and any same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited requests, in-order response tagging,
// redirect flush with in-flight drop. Optional stop address: INSTR_FETCH_STOP_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
`ifdef INSTR_FETCH_STOP_EN
    ,
    input  logic [XLEN-1:0] last_pc
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            grant;
    logic            keep;
    logic            pop;
    logic            stop_hit;
    logic            fifo_empty;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Every outstanding request already owns a FIFO slot, so the buffer can never overflow.
    assign credit_used = {1'b0, inflight} + {1'b0, count};
    assign mem_req     = (credit_used < (CW+1)'(DEPTH)) && (state == RUN);
    assign mem_addr    = fetch_pc;
    assign grant       = mem_req && mem_gnt;
    assign keep        = mem_rvalid && (drop_cnt == '0) && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign push_entry  = '{pc: resp_pc, data: mem_rdata};

`ifdef INSTR_FETCH_STOP_EN
    assign stop_hit = grant && (fetch_pc == last_pc);
`else
    assign stop_hit = 1'b0;
`endif

    always_comb begin
        inflight_next = inflight;
        case ({grant, mem_rvalid})
            2'b10:   inflight_next = inflight + CW'(1);
            2'b01:   inflight_next = inflight - CW'(1);
            default: inflight_next = inflight;
        endcase
    end

    // On redirect everything still outstanding, including this cycle's grant, becomes a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect) begin
                state    <= RUN;
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= inflight_next;
            end else begin
                if (grant) fetch_pc <= fetch_pc + XLEN'(1);
                if (mem_rvalid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                resp_pc  <= resp_pc + XLEN'(1);
                end
                if (stop_hit) state <= HALT;
            end
        end
    end

    instr_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep),
        .push_entry(push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr_pc    = head.pc;
    assign instr_data  = head.data;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: a queued memory model plus an instruction-stream
// reference (PCs run sequentially from the last redirect, data is a hash of the PC).
module tb_instr_fetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
`ifdef INSTR_FETCH_STOP_EN
    logic [31:0] last_pc = 32'hFFFF_FF00;
`endif

    instr_fetch #(
        .DEPTH   (DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_pc   (instr_pc),
        .instr_ready(instr_ready)
`ifdef INSTR_FETCH_STOP_EN
        ,
        .last_pc    (last_pc)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] pop_log[$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          grants = 0;
    int          pops = 0;
    int          buffered = 0;
    int          drops = 0;
    bit          halted = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs against the model at the negedge, drive inputs, advance the model.
    task automatic applyStimulus(input bit do_redir, input logic [31:0] rpc);
        bit       grant_now;
        bit       resp_now;
        bit       pop_now;
        bit       exp_req;
        mem_txn_t txn;
        @(negedge clk);
        exp_req = !halted && ((mem_q.size() + buffered) < DEPTH);
        checkOutput("mem_req", 32'(mem_req), 32'(exp_req));
        if (mem_req) checkOutput("mem_addr", mem_addr, exp_fetch);
        checkOutput("instr_valid", 32'(instr_valid), 32'(buffered > 0));

        resp_now    = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        mem_gnt     = ($urandom_range(99) < gnt_pct);
        mem_rvalid  = resp_now;
        mem_rdata   = resp_now ? word_of(mem_q[0].addr) : $urandom;
        instr_ready = ($urandom_range(99) < ready_pct);
        redirect    = do_redir;
        redirect_pc = do_redir ? rpc : $urandom;

        grant_now = mem_req && mem_gnt;
        pop_now   = instr_valid && instr_ready && !do_redir;

        if (pop_now) begin
            checkOutput("instr_pc", instr_pc, exp_pc);
            checkOutput("instr_data", instr_data, word_of(exp_pc));
            pop_log.push_back(instr_pc);
            exp_pc = exp_pc + 32'd1;
            buffered--;
            pops++;
        end
        if (resp_now) begin
            void'(mem_q.pop_front());
            if (!do_redir) begin
                if (drops > 0) drops--;
                else           buffered++;
            end
        end
        if (grant_now) begin
            txn.addr = mem_addr;
            txn.due  = cyc + $urandom_range(lat_max, lat_min);
            mem_q.push_back(txn);
            grants++;
`ifdef INSTR_FETCH_STOP_EN
            if (mem_addr == last_pc) halted = 1'b1;
`endif
            exp_fetch = exp_fetch + 32'd1;
        end
        if (do_redir) begin
            buffered  = 0;
            drops     = mem_q.size();
            exp_pc    = rpc;
            exp_fetch = rpc;
            halted    = 1'b0;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n       = 1'b0;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        mem_q.delete();
        buffered  = 0;
        drops     = 0;
        halted    = 1'b0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mem_req", 32'(mem_req), 32'd1);
        checkOutput("rst_mem_addr", mem_addr, RESET_PC);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr_data", instr_data, 32'd0);
        checkOutput("rst_instr_pc", instr_pc, 32'd0);
    endtask

    task automatic waitPops(input int n, input int budget, input string tag);
        int start;
        start = pops;
        for (int i = 0; i < budget && (pops - start) < n; i++) applyStimulus(1'b0, 32'd0);
        checkOutput(tag, 32'(pops - start >= n), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int g0;
        logic [31:0] rpc;

        doReset();

        // Single-cycle memory, core always ready: 2-cycle startup then one per cycle.
        g0 = pops;
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'd0);
        checkOutput("thru_pops", 32'(pops - g0), 32'd18);

        // Backpressure: exactly DEPTH grants, then one more per popped word.
        gnt_pct = 0;
        ready_pct = 0;
        applyStimulus(1'b1, 32'h100);
        gnt_pct = 100;
        g0 = grants;
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'd0);
        checkOutput("bp_grants", 32'(grants - g0), 32'(DEPTH));
        #1;
        checkOutput("bp_req_low", 32'(mem_req), 32'd0);
        g0 = grants;
        ready_pct = 100;
        applyStimulus(1'b0, 32'd0);
        ready_pct = 0;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd0);
        checkOutput("bp_one_more", 32'(grants - g0), 32'd1);

        // 3-cycle latency redirect with requests in flight.
        ready_pct = 100;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_q.size() >= 2) break;
            applyStimulus(1'b0, 32'd0);
        end
        applyStimulus(1'b1, 32'h40);
        pop_log.delete();
        waitPops(1, 30, "redir_wait");
        if (pop_log.size() > 0) checkOutput("redir_first_pc", pop_log[0], 32'h40);

        // Redirect coinciding with a response and a grant.
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_req && mem_q.size() > 0 && mem_q[0].due <= cyc) break;
            applyStimulus(1'b0, 32'd0);
        end
        applyStimulus(1'b1, 32'h2000);
        #1;
        checkOutput("no_stale_valid", 32'(instr_valid), 32'd0);
        pop_log.delete();
        waitPops(2, 30, "same_cycle_wait");
        if (pop_log.size() > 1) begin
            checkOutput("same_cycle_pc0", pop_log[0], 32'h2000);
            checkOutput("same_cycle_pc1", pop_log[1], 32'h2001);
        end

        // PC wraparound.
        lat_min = 1;
        lat_max = 3;
        applyStimulus(1'b1, 32'hFFFF_FFFE);
        pop_log.delete();
        waitPops(3, 40, "wrap_wait");
        if (pop_log.size() > 2) begin
            checkOutput("wrap_pc0", pop_log[0], 32'hFFFF_FFFE);
            checkOutput("wrap_pc1", pop_log[1], 32'hFFFF_FFFF);
            checkOutput("wrap_pc2", pop_log[2], 32'h0000_0000);
        end

`ifdef INSTR_FETCH_STOP_EN
        // Stop address: words 0..5 delivered, then requests stay off until redirect.
        lat_min = 1;
        lat_max = 1;
        last_pc = 32'd5;
        applyStimulus(1'b1, 32'd0);
        pop_log.delete();
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 32'd0);
        checkOutput("stop_count", 32'(pop_log.size()), 32'd6);
        if (pop_log.size() > 0) checkOutput("stop_last", pop_log[pop_log.size()-1], 32'd5);
        #1;
        checkOutput("stop_req_low", 32'(mem_req), 32'd0);
        last_pc = 32'hFFFF_FF00;
        applyStimulus(1'b1, 32'd0);
        waitPops(3, 20, "stop_resume");
`endif

        // Random traffic with occasional redirects and mid-run resets.
        gnt_pct = 70;
        ready_pct = 60;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(999) < 3) begin
                doReset();
            end else if ($urandom_range(99) < 2) begin
                rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15))) : $urandom;
                applyStimulus(1'b1, rpc);
            end else begin
                applyStimulus(1'b0, 32'd0);
            end
        end
        gnt_pct = 100;
        ready_pct = 100;
        waitPops(4, 40, "final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
